fp_to_fixed_pipe: RTL and testbench
===================================

// Module: fp_to_fixed_pipe
// PURPOSE
//  Pipelined, handshaked successor to the combinational float->fixed converter.
//  Converts IEEE-754 binary32 to signed two's-complement Q.F fixed point
//  with run-time rounding mode, saturation and exception flags.
//  Sits between the TinyQV peripheral register file and the CORDIC core input;
//  accepts one operand per cycle under valid/ready backpressure.
// PARAMETERS
//  Q  4   integer bits incl. sign (2..16)
//  F  23  fraction bits (1..30); W = Q+F <= 32
// PORTS
//  clk        in   1    clock; everything on rising edge
//  rst        in   1    reset, asynchronous, active-high
//  in_valid   in   1    operand offered
//  in_ready   out  1    converter can accept (combinational from state + out_ready)
//  in_data    in   32   binary32 operand
//  in_rnd     in   2    rounding mode, sampled with the operand
//  out_valid  out  1    result available
//  out_ready  in   1    consumer accepts result
//  out_data   out  W    signed Q.F result
//  out_flags  out  3    [0] inexact, [1] overflow/saturated, [2] invalid (NaN)
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_flags=0, both stage valids=0; in-flight beats dropped.
//    in_ready=1 out of reset.
//  - Handshake: beat moves on valid&&ready. out_data/out_flags stay stable while out_valid&&!out_ready.
//  - Two stages; full throughput (1/cycle). Accepted in cycle N -> out_valid in cycle N+2 if unstalled.
//  - S1 advances when S2 is empty or draining. in_ready = !s1_v || s1_adv.
//  - S1 (unpack): s, e, m={1,frac}, sh = e-150+F (signed 10b), class {zero, normal, inf, nan}, rnd.
//  - S2 (shift/round/sat):
//    - sh>=0: mag=m<<sh, exact.
//    - sh<0: mag=m>>-sh, with guard and sticky from the shifted-out bits; sh<-25 gives mag=0 and inexact.
//  - Rounding, applied on magnitude then negated if s:
//    - 00 RTZ: never increment.
//    - 01 RNE: inc if guard && (sticky || mag[0]).
//    - 10 floor: inc if s && inexact.
//    - 11 ceil: inc if !s && inexact.
//  - Saturation: limit = 2^(W-1)-1 (s=0) or 2^(W-1) (s=1), checked after rounding increment.
//    Exceed -> out = 0x0111..1 / 0x1000..0, flags[1]=1. Overflow clears inexact.
//  - e==0 (zero/subnormal): flush to 0. flags[0]=1 iff frac!=0.
//  - e==255, frac==0 (Inf): saturate per sign, flags[1]=1.
//  - e==255, frac!=0 (NaN): out=0, flags[2]=1.
//  - -0.0 -> 0, no flags.
//  - Simultaneous out handshake and in handshake in the same cycle: pipeline shifts, no bubble.
// STRUCTURE
//  - Shared package fpfx_pkg: round_mode_e {RND_RTZ, RND_RNE, RND_FLOOR, RND_CEIL};
//    fp_class_e; FLAG_INEXACT/FLAG_OVF/FLAG_INV index constants.
//  - One sub-module, fpfx_round_sat: combinational S2 shift+round+saturate, parametrised on Q, F.
//    Top file holds the two pipeline registers and handshake only.
// TESTING (Q=4, F=23, W=27)
//  - 0x3F800000 (1.0), RTZ -> 0x0800000, flags 0; -1.5 0xBFC00000 -> 0x7400000, flags 0.
//  - 10.0 0x41200000 -> 0x3FFFFFF, flags=010; -8.0 0xC1000000 -> 0x4000000, flags 0; +Inf 0x7F800000 -> 0x3FFFFFF, 010.
//  - 0x3F000001: RNE -> 0x0400000 (tie, even), CEIL -> 0x0400001, flags 001.
//    0x3F000003 RNE -> 0x0400002; 0xBF000001 FLOOR -> 0x7BFFFFF.
//  - NaN 0x7FC00000 -> 0, flags=100; subnormal 0x00000001 -> 0, flags=001; 0x80000000 -> 0, flags 000.
//  - Stream 8 back-to-back beats, out_ready=0 for cycles 3..6: no loss/dup, order kept,
//    out_data stable while stalled, in_ready drops only when both stages full.
//  - Assert rst with 2 beats in flight: out_valid falls asynchronously to 0, nothing emitted after release.

Source files
------------

// File: rtl/fpfx_pkg.sv
// Shared types and helpers for the binary32 -> signed Q.F converter pipeline.
// The unpack helper builds the stage-1 payload straight from the operand bits.
package fpfx_pkg;

    typedef enum logic [1:0] {
        RND_RTZ   = 2'd0,
        RND_RNE   = 2'd1,
        RND_FLOOR = 2'd2,
        RND_CEIL  = 2'd3
    } round_mode_e;

    typedef enum logic [1:0] {
        CLS_ZERO   = 2'd0,
        CLS_NORMAL = 2'd1,
        CLS_INF    = 2'd2,
        CLS_NAN    = 2'd3
    } fp_class_e;

    localparam int FLAG_INEXACT = 0;
    localparam int FLAG_OVF     = 1;
    localparam int FLAG_INV     = 2;

    // Stage-1 payload: sh is a signed 10-bit left-shift amount of m
    typedef struct packed {
        logic        s;
        logic [23:0] m;
        logic [9:0]  sh;
        fp_class_e   cls;
        round_mode_e rnd;
        logic        frac_nz;
    } s1_t;

    function automatic s1_t fpfx_unpack(input logic [31:0] x, input logic [1:0] rnd,
                                        input int frac_bits);
        s1_t         u;
        logic [7:0]  e;
        logic [22:0] frac;
        e         = x[30:23];
        frac      = x[22:0];
        u.s       = x[31];
        u.m       = {1'b1, frac};
        u.sh      = {2'b00, e} - 10'd150 + 10'(frac_bits);
        u.frac_nz = |frac;
        u.rnd     = round_mode_e'(rnd);
        if (e == 8'd0)
            u.cls = CLS_ZERO;
        else if (e == 8'hFF)
            u.cls = u.frac_nz ? CLS_NAN : CLS_INF;
        else
            u.cls = CLS_NORMAL;
        return u;
    endfunction

endpackage

// File: rtl/fpfx_round_sat.sv
// Stage-2 datapath: align the 24-bit significand, round per mode on the
// magnitude, saturate against the signed Q.F range, then apply the sign.
module fpfx_round_sat
    import fpfx_pkg::*;
#(
    parameter int Q = 4,
    parameter int F = 23
) (
    input  logic             s_i,
    input  logic [23:0]      m_i,
    input  logic [9:0]       sh_i,
    input  logic [1:0]       cls_i,
    input  logic [1:0]       rnd_i,
    input  logic             frac_nz_i,
    output logic [Q+F-1:0]   data_o,
    output logic [2:0]       flags_o
);
    localparam int W = Q + F;
    localparam logic [64:0]  LIM_POS = (65'd1 << (W - 1)) - 65'd1;
    localparam logic [64:0]  LIM_NEG = 65'd1 << (W - 1);
    localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

    logic signed [9:0] sh;
    logic [4:0]        nsh;
    logic [49:0]       rsh;
    logic [63:0]       mag;
    logic [64:0]       mag_r;
    logic [W-1:0]      mag_w;
    logic              guard, sticky, big, inexact, inc, ovf;

    assign sh  = $signed(sh_i);
    assign nsh = 5'd0 - sh_i[4:0];
    assign rsh = {m_i, 26'd0} >> nsh;

    // Left shifts beyond 40 already exceed any W<=32 range; flag as big
    always_comb begin
        mag    = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        big    = 1'b0;
        if (!sh[9]) begin
            if (sh > 10'sd40)
                big = 1'b1;
            else
                mag = {40'd0, m_i} << sh[5:0];
        end else if (sh < -10'sd25) begin
            sticky = 1'b1;
        end else begin
            mag    = {40'd0, rsh[49:26]};
            guard  = rsh[25];
            sticky = |rsh[24:0];
        end
    end

    assign inexact = guard | sticky;

    always_comb begin
        inc = 1'b0;
        case (round_mode_e'(rnd_i))
            RND_RTZ:   inc = 1'b0;
            RND_RNE:   inc = guard & (sticky | mag[0]);
            RND_FLOOR: inc = s_i & inexact;
            RND_CEIL:  inc = ~s_i & inexact;
            default:   inc = 1'b0;
        endcase
    end

    assign mag_r = {1'b0, mag} + {64'd0, inc};
    assign ovf   = big | (mag_r > (s_i ? LIM_NEG : LIM_POS));
    assign mag_w = mag_r[W-1:0];

    always_comb begin
        data_o  = '0;
        flags_o = '0;
        case (fp_class_e'(cls_i))
            CLS_NAN:  flags_o[FLAG_INV] = 1'b1;
            CLS_INF: begin
                data_o            = s_i ? SAT_NEG : SAT_POS;
                flags_o[FLAG_OVF] = 1'b1;
            end
            CLS_ZERO: flags_o[FLAG_INEXACT] = frac_nz_i;
            default: begin
                if (ovf) begin
                    data_o            = s_i ? SAT_NEG : SAT_POS;
                    flags_o[FLAG_OVF] = 1'b1;
                end else begin
                    data_o                = s_i ? ({W{1'b0}} - mag_w) : mag_w;
                    flags_o[FLAG_INEXACT] = inexact;
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_to_fixed_pipe.sv
// Two-stage valid/ready binary32 -> signed Q.F converter: S1 holds the
// unpacked operand, S2 holds the rounded/saturated result.
module fp_to_fixed_pipe
    import fpfx_pkg::*;
#(
    parameter int Q = 4,
    parameter int F = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [1:0]       in_rnd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Q+F-1:0]   out_data,
    output logic [2:0]       out_flags
);
    localparam int W = Q + F;

    s1_t          s1_q, s1_d;
    logic         s1_v_q, s1_v_d;
    logic         out_v_q, out_v_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [2:0]   out_flags_q, out_flags_d;
    logic         s2_adv, s1_adv;
    logic [W-1:0] rs_data;
    logic [2:0]   rs_flags;

    assign s2_adv   = !out_v_q || out_ready;
    assign s1_adv   = s1_v_q && s2_adv;
    assign in_ready = !s1_v_q || s1_adv;

    fpfx_round_sat #(.Q(Q), .F(F)) u_round_sat (
        .s_i       (s1_q.s),
        .m_i       (s1_q.m),
        .sh_i      (s1_q.sh),
        .cls_i     (s1_q.cls),
        .rnd_i     (s1_q.rnd),
        .frac_nz_i (s1_q.frac_nz),
        .data_o    (rs_data),
        .flags_o   (rs_flags)
    );

    // Result registers only load on a real S1->S2 move, so a stalled output holds
    always_comb begin
        s1_v_d      = s1_v_q;
        s1_d        = s1_q;
        out_v_d     = out_v_q;
        out_data_d  = out_data_q;
        out_flags_d = out_flags_q;
        if (s2_adv) begin
            out_v_d = s1_v_q;
            if (s1_v_q) begin
                out_data_d  = rs_data;
                out_flags_d = rs_flags;
            end
        end
        if (in_ready) begin
            s1_v_d = in_valid;
            if (in_valid)
                s1_d = fpfx_unpack(in_data, in_rnd, F);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q        <= '0;
            s1_v_q      <= 1'b0;
            out_v_q     <= 1'b0;
            out_data_q  <= '0;
            out_flags_q <= '0;
        end else begin
            s1_q        <= s1_d;
            s1_v_q      <= s1_v_d;
            out_v_q     <= out_v_d;
            out_data_q  <= out_data_d;
            out_flags_q <= out_flags_d;
        end
    end

    assign out_valid = out_v_q;
    assign out_data  = out_data_q;
    assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fp_to_fixed_pipe.sv
// Scoreboard bench for fp_to_fixed_pipe at Q=4, F=23: directed vectors with
// latency checks, a stalled back-to-back stream, and reset with beats in flight.
module tb_fp_to_fixed_pipe;
    localparam int Q = 4;
    localparam int F = 23;
    localparam int W = Q + F;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]  in_data;
    logic [1:0]   in_rnd;
    logic [W-1:0] out_data;
    logic [2:0]   out_flags;

    typedef struct {
        logic [31:0]  x;
        logic [1:0]   r;
        logic [W-1:0] d;
        logic [2:0]   f;
    } vec_t;
    typedef struct {
        logic [W-1:0] d;
        logic [2:0]   f;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t drv_exp, got_e;
    int   checks = 0, errors = 0;
    int   in_flight = 0, n_out = 0, in_ready_lows = 0;
    logic         hold_v = 1'b0;
    logic [W-1:0] hold_d;
    logic [2:0]   hold_f;

    always #5 clk = ~clk;

    fp_to_fixed_pipe #(.Q(Q), .F(F)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_rnd    (in_rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    // Monitor: scoreboard pop on output handshake, push on input handshake
    always @(negedge clk) begin
        if (rst) begin
            in_flight = 0;
            hold_v    = 1'b0;
        end else begin
            checks++;
            if (in_ready !== !(in_flight == 2 && !out_ready)) begin
                errors++;
                $display("FAIL in_ready: got %b, expected %b (in flight %0d)",
                         in_ready, !(in_flight == 2 && !out_ready), in_flight);
            end
            if (!in_ready) in_ready_lows++;
            if (hold_v) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== hold_d || out_flags !== hold_f) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b %h/%b, expected v=1 %h/%b",
                             out_valid, out_data, out_flags, hold_d, hold_f);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %h/%b, expected no output",
                             out_data, out_flags);
                end else begin
                    got_e = sb.pop_front();
                    if (out_data !== got_e.d || out_flags !== got_e.f) begin
                        errors++;
                        $display("FAIL result: got %h flags %b, expected %h flags %b",
                                 out_data, out_flags, got_e.d, got_e.f);
                    end
                end
                n_out++;
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_f = out_flags;
            if (in_valid && in_ready) sb.push_back(drv_exp);
            in_flight = in_flight + ((in_valid && in_ready) ? 1 : 0)
                                  - ((out_valid && out_ready) ? 1 : 0);
        end
    end

    function automatic void add(input logic [31:0] x, input logic [1:0] r,
                                input logic [W-1:0] d, input logic [2:0] f);
        vec_t v;
        v.x = x; v.r = r; v.d = d; v.f = f;
        vecs.push_back(v);
    endfunction

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_rnd = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", out_valid); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h, expected 0", out_data); end
        checks++;
        if (out_flags !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b, expected 000", out_flags); end
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed;
        int n0;
        n0 = n_out;
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            in_valid = 1'b1; in_data = vecs[i].x; in_rnd = vecs[i].r;
            drv_exp.d = vecs[i].d; drv_exp.f = vecs[i].f;
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_n1 vec%0d: got %b, expected 0", i, out_valid); end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_n2 vec%0d: got %b, expected 1", i, out_valid); end
            @(posedge clk);
            #1;
        end
        checks++;
        if (n_out - n0 != vecs.size() || sb.size() != 0) begin
            errors++;
            $display("FAIL directed_count: got %0d outputs (%0d pending), expected %0d",
                     n_out - n0, sb.size(), vecs.size());
        end
    endtask

    task automatic test_back_to_back;
        int   sent, n0, lows0;
        logic acc;
        sent = 0; n0 = n_out; lows0 = in_ready_lows;
        fork
            begin
                for (int c = 0; c < 60 && sent < 8; c++) begin
                    in_valid = 1'b1; in_data = vecs[sent].x; in_rnd = vecs[sent].r;
                    drv_exp.d = vecs[sent].d; drv_exp.f = vecs[sent].f;
                    @(negedge clk);
                    acc = in_ready;
                    @(posedge clk);
                    #1;
                    if (acc) sent++;
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    out_ready = !(c >= 3 && c <= 6);
                    @(posedge clk);
                    #1;
                end
            end
        join
        checks++;
        if (sent != 8) begin errors++; $display("FAIL stream_sent: got %0d, expected 8", sent); end
        checks++;
        if (n_out - n0 != 8 || sb.size() != 0) begin
            errors++;
            $display("FAIL stream_count: got %0d outputs (%0d pending), expected 8", n_out - n0, sb.size());
        end
        checks++;
        if (in_ready_lows == lows0) begin errors++; $display("FAIL stream_backpressure: got no in_ready low, expected some"); end
    endtask

    task automatic test_reset_inflight;
        int seen;
        seen = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_data = vecs[k].x; in_rnd = vecs[k].r;
            drv_exp.d = vecs[k].d; drv_exp.f = vecs[k].f;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL inflight_valid: got %b, expected 1", out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_flags !== 3'b000) begin
            errors++;
            $display("FAIL async_reset: got v=%b %h/%b, expected v=0 0/000", out_valid, out_data, out_flags);
        end
        sb.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL post_reset_output: got %0d beats, expected 0", seen); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b, expected 1", in_ready); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_rnd = '0; out_ready = 1'b1;
        add(32'h3F800000, 2'd0, 27'h0800000, 3'b000);
        add(32'hBFC00000, 2'd0, 27'h7400000, 3'b000);
        add(32'h41200000, 2'd0, 27'h3FFFFFF, 3'b010);
        add(32'hC1000000, 2'd0, 27'h4000000, 3'b000);
        add(32'h7F800000, 2'd0, 27'h3FFFFFF, 3'b010);
        add(32'hFF800000, 2'd0, 27'h4000000, 3'b010);
        add(32'h3F000001, 2'd1, 27'h0400000, 3'b001);
        add(32'h3F000001, 2'd3, 27'h0400001, 3'b001);
        add(32'h3F000001, 2'd0, 27'h0400000, 3'b001);
        add(32'h3F000003, 2'd1, 27'h0400002, 3'b001);
        add(32'hBF000001, 2'd2, 27'h7BFFFFF, 3'b001);
        add(32'hBF000001, 2'd3, 27'h7C00000, 3'b001);
        add(32'h7FC00000, 2'd0, 27'h0000000, 3'b100);
        add(32'h00000001, 2'd0, 27'h0000000, 3'b001);
        add(32'h80000000, 2'd0, 27'h0000000, 3'b000);
        add(32'hC1100000, 2'd0, 27'h4000000, 3'b010);
        add(32'h40FFFFFF, 2'd0, 27'h3FFFFFC, 3'b000);
        add(32'h33000000, 2'd3, 27'h0000001, 3'b001);
        add(32'hB3000000, 2'd2, 27'h7FFFFFF, 3'b001);
        add(32'h33800000, 2'd1, 27'h0000000, 3'b001);
        add(32'h33800001, 2'd1, 27'h0000001, 3'b001);
        add(32'h00800000, 2'd0, 27'h0000000, 3'b001);
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
